uart_tx_fifo: RTL and testbench

- Byte buffer and launcher sitting directly upstream of the UART transmitter.
- Accepts bytes from a host/bus side and stores them in a circular FIFO.
- Feeds the transmitter one byte at a time through a start/active/done handshake, so back-to-back bytes go out without host pacing.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo_if.sv | 36 +++
 rtl/uart_fifo_mem.sv | 71 +++++++
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: byte width and launcher FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] byte_t;
    typedef logic [1:0]        state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t LAUNCH    = 2'd1;
    localparam state_t WAIT_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Host write port plus transmitter start/active/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    import uart_pkg::*;

    logic                i_wr_en;
    byte_t               i_wr_data;
    logic                o_full;
    logic                o_empty;
    logic [DEPTH_LOG2:0] o_count;
    logic                o_tx_start;
    byte_t               o_tx_data;
    logic                i_tx_active;
    logic                i_tx_done;
    logic                o_busy;
    logic                o_overflow;
    logic                i_ovf_clr;

    modport master (
        output i_wr_en, i_wr_data, i_tx_active, i_tx_done, i_ovf_clr,
        input  o_full, o_empty, o_count, o_tx_start, o_tx_data, o_busy, o_overflow
    );

    modport slave (
        input  i_wr_en, i_wr_data, i_tx_active, i_tx_done, i_ovf_clr,
        output o_full, o_empty, o_count, o_tx_start, o_tx_data, o_busy, o_overflow
    );

endinterface
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_mem
// Description : Circular byte FIFO storage with pointers and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic                i_Clock,
    input  wire logic                i_reset,
    input  wire logic                i_wr_en,
    input  wire byte_t               i_wr_data,
    input  wire logic                i_rd_en,
    output      byte_t               o_rd_data,
    output      logic                o_wr_drop,
    output      logic [DEPTH_LOG2:0] o_count,
    output      logic                o_full,
    output      logic                o_empty
);

    localparam int                  DEPTH        = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_count = (DEPTH_LOG2 + 1)'(DEPTH);

    byte_t                 r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_full;
    logic                  w_wr_accept;

    assign w_full      = (r_count == c_full_count);
    // A pop in the same cycle frees the slot the write lands in.
    assign w_wr_accept = i_wr_en && (!w_full || i_rd_en);

    always_ff @(posedge i_Clock) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_accept, i_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_wr_drop = i_wr_en && !w_wr_accept;
    assign o_count   = r_count;
    assign o_full    = w_full;
    assign o_empty   = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO plus launcher feeding a UART transmitter; the sticky
//               overflow flag is built only when UART_TX_FIFO_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic      i_Clock,
    input  wire logic      i_reset,
    uart_tx_fifo_if.slave  bus
);

    state_t              r_state;
    state_t              w_next_state;
    byte_t               r_tx_data;
    byte_t               w_rd_data;
    logic                w_pop;
    logic                w_wr_drop;
    logic                w_empty;
    logic                w_tx_start;
    logic                w_busy;
    logic [DEPTH_LOG2:0] w_count;

    assign w_pop = (r_state == IDLE) && !w_empty && !bus.i_tx_active;

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .i_Clock   (i_Clock),
        .i_reset   (i_reset),
        .i_wr_en   (bus.i_wr_en),
        .i_wr_data (bus.i_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_wr_drop (w_wr_drop),
        .o_count   (w_count),
        .o_full    (bus.o_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE:      w_next_state = w_pop ? LAUNCH : IDLE;
            LAUNCH:    w_next_state = bus.i_tx_active ? WAIT_DONE : LAUNCH;
            WAIT_DONE: w_next_state = bus.i_tx_done ? IDLE : WAIT_DONE;
            default:   w_next_state = IDLE;
        endcase
    end

    // Start is a level held for the whole LAUNCH state, decoded from the state register.
    always_comb begin
        w_tx_start = (r_state == LAUNCH);
        w_busy     = (r_state != IDLE);
    end

    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            r_tx_data <= '0;
        end else if (w_pop) begin
            r_tx_data <= w_rd_data;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic r_overflow;

    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            r_overflow <= 1'b0;
        end else if (w_wr_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.o_overflow = r_overflow;
`else
    logic w_unused_ovf;

    assign w_unused_ovf   = bus.i_ovf_clr | w_wr_drop;
    assign bus.o_overflow = 1'b0;
`endif

    assign bus.o_tx_start = w_tx_start;
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_busy     = w_busy;
    assign bus.o_empty    = w_empty;
    assign bus.o_count    = w_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo with a transmitter model;
//               expectations follow UART_TX_FIFO_OVF_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 2 ** DEPTH_LOG2;
`ifdef UART_TX_FIFO_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .i_Clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    // Transmitter model: accepts a start while enabled and idle, stays active
    // for m_len+1 cycles, then pulses done as active falls.
    logic  m_active;
    logic  m_done;
    int    m_left;
    int    m_len;
    logic  m_en;
    logic  force_busy;
    byte_t got[$];

    assign bus.i_tx_active = m_active | force_busy;
    assign bus.i_tx_done   = m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_left   <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (bus.o_tx_start && m_en) begin
                    m_active <= 1'b1;
                    m_left   <= m_len;
                    got.push_back(bus.o_tx_data);
                end
            end else if (m_left == 0) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    int    n_cmp = 0;
    int    n_err = 0;
    int    n_starts = 0;
    int    n_dones = 0;
    int    cmp_idx = 0;
    logic  prev_start = 1'b0;
    byte_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.o_tx_start && !prev_start) n_starts++;
        prev_start = bus.o_tx_start;
        if (m_done) n_dones++;
    endtask

    task automatic push_wr(input byte_t d, input logic expect_accept);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = d;
        if (expect_accept) exp_q.push_back(d);
        tick();
        bus.i_wr_en   = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic ok;
        ok = 1'b0;
        force_busy = 1'b0;
        m_en       = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (bus.o_empty && !bus.o_busy && !m_active) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, got.size(), exp_q.size());
        for (int i = cmp_idx; i < got.size() && i < exp_q.size(); i++) begin
            check({tag, "_byte"}, got[i], exp_q[i]);
        end
        cmp_idx = got.size();
    endtask

    task automatic fill_stalled(input int n);
        force_busy = 1'b1;
        bus.i_wr_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.i_wr_data = byte_t'($urandom_range(0, 254));
            exp_q.push_back(bus.i_wr_data);
            tick();
        end
        bus.i_wr_en = 1'b0;
    endtask

    initial begin
        int    s0;
        int    d0;
        int    st0;
        int    acc;
        int    start_cycles;
        logic  seen;
        byte_t first_b;

        bus.i_wr_en   = 1'b0;
        bus.i_wr_data = '0;
        bus.i_ovf_clr = 1'b0;
        m_en          = 1'b1;
        m_len         = 2;
        force_busy    = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();

        check("rst_start",    bus.o_tx_start, 0);
        check("rst_data",     bus.o_tx_data,  0);
        check("rst_empty",    bus.o_empty,    1);
        check("rst_full",     bus.o_full,     0);
        check("rst_count",    bus.o_count,    0);
        check("rst_busy",     bus.o_busy,     0);
        check("rst_overflow", bus.o_overflow, 0);
        rst_n = 1'b1;
        tick();

        // Single byte
        push_wr(8'hA5, 1'b1);
        check("single_count_after_wr", bus.o_count, 1);
        start_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.o_tx_start) begin
                start_cycles++;
                check("single_data", bus.o_tx_data, 8'hA5);
            end
            if (m_done) seen = 1'b1;
        end
        check("single_done_seen", seen, 1);
        check("single_start_cycles", start_cycles, 2);
        check("single_count_end", bus.o_count, 0);
        tick();
        check("single_busy_after_done", bus.o_busy, 0);
        compare_stream("single_stream");

        // Burst of 16 with transmitter held busy
        force_busy = 1'b1;
        bus.i_wr_en = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            bus.i_wr_data = byte_t'(i);
            exp_q.push_back(byte_t'(i));
            tick();
        end
        bus.i_wr_en = 1'b0;
        check("burst_full",  bus.o_full,  1);
        check("burst_count", bus.o_count, DEPTH);
        check("burst_empty", bus.o_empty, 0);
        s0 = n_starts;
        d0 = n_dones;
        m_len = $urandom_range(0, 4);
        drain("burst_drain");
        check("burst_starts", n_starts - s0, DEPTH);
        check("burst_dones",  n_dones - d0,  DEPTH);
        check("burst_empty_end", bus.o_empty, 1);
        compare_stream("burst_stream");

        // Overflow
        fill_stalled(DEPTH);
        check("ovf_full", bus.o_full, 1);
        push_wr(8'hFF, 1'b0);
        check("ovf_count", bus.o_count, DEPTH);
        check("ovf_set", bus.o_overflow, OVF_EXP);
        tick();
        check("ovf_sticky", bus.o_overflow, OVF_EXP);
        bus.i_ovf_clr = 1'b1;
        tick();
        bus.i_ovf_clr = 1'b0;
        check("ovf_clr", bus.o_overflow, 0);
        bus.i_ovf_clr = 1'b1;
        push_wr(8'hFF, 1'b0);
        bus.i_ovf_clr = 1'b0;
        check("ovf_set_wins", bus.o_overflow, OVF_EXP);
        bus.i_ovf_clr = 1'b1;
        tick();
        bus.i_ovf_clr = 1'b0;
        check("ovf_clr2", bus.o_overflow, 0);
        drain("ovf_drain");
        compare_stream("ovf_stream");

        // Full FIFO: write coincides with the pop
        fill_stalled(DEPTH);
        first_b = exp_q[got.size()];
        force_busy = 1'b0;
        push_wr(8'h55, 1'b1);
        check("wp_count", bus.o_count, DEPTH);
        check("wp_start", bus.o_tx_start, 1);
        check("wp_data",  bus.o_tx_data, first_b);
        check("wp_no_ovf", bus.o_overflow, 0);
        drain("wp_drain");
        compare_stream("wp_stream");

        // Stalled transmitter holds the request
        m_en = 1'b0;
        push_wr(8'h3C, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.o_tx_start) seen = 1'b1;
            else tick();
        end
        check("stall_start_seen", seen, 1);
        push_wr(8'h77, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("stall_start", bus.o_tx_start, 1);
            check("stall_data",  bus.o_tx_data, 8'h3C);
            check("stall_count", bus.o_count, 1);
            tick();
        end
        m_en = 1'b1;
        tick();
        check("stall_active_up", bus.i_tx_active, 1);
        check("stall_start_hold", bus.o_tx_start, 1);
        tick();
        check("stall_start_drop", bus.o_tx_start, 0);
        drain("stall_drain");
        compare_stream("stall_stream");

        // Async reset while waiting for done with bytes queued
        m_len = 10;
        fill_stalled(6);
        force_busy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.o_busy && !bus.o_tx_start && m_active) seen = 1'b1;
        end
        check("rstmid_wait_done_seen", seen, 1);
        check("rstmid_count_before", bus.o_count, 5);
        while (exp_q.size() > got.size()) void'(exp_q.pop_back());
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_start",    bus.o_tx_start, 0);
        check("rstmid_data",     bus.o_tx_data,  0);
        check("rstmid_count",    bus.o_count,    0);
        check("rstmid_empty",    bus.o_empty,    1);
        check("rstmid_full",     bus.o_full,     0);
        check("rstmid_busy",     bus.o_busy,     0);
        check("rstmid_overflow", bus.o_overflow, 0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.o_tx_start) seen = 1'b1;
        end
        check("rstmid_no_start", seen, 0);
        m_len = 1;
        push_wr(8'h5A, 1'b1);
        drain("rstmid_drain");
        compare_stream("rstmid_stream");

        // Randomized traffic against an occupancy model
        st0 = n_starts;
        acc = 0;
        for (int c = 0; c < 400; c++) begin
            m_len = $urandom_range(0, 5);
            m_en  = ($urandom_range(0, 7) != 0);
            if ((acc - (n_starts - st0)) < DEPTH && $urandom_range(0, 1) == 1) begin
                bus.i_wr_en   = 1'b1;
                bus.i_wr_data = byte_t'($urandom);
                exp_q.push_back(bus.i_wr_data);
                acc++;
            end else begin
                bus.i_wr_en = 1'b0;
            end
            tick();
            check("rnd_count", bus.o_count, acc - (n_starts - st0));
        end
        bus.i_wr_en = 1'b0;
        drain("rnd_drain");
        check("rnd_no_ovf", bus.o_overflow, 0);
        compare_stream("rnd_stream");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
